// File: rtl/llc_plru_array.sv
// llc_plru_array: per-set tree-PLRU replacement state for a last-level cache.
// Each set stores an (ASSOCIATIVITY-1)-bit tree vector. Requests can TOUCH a way,
// pick and claim a VICTIM, or QUERY the victim without changing state.
// On reset, an INIT sweep clears every set, one set per cycle, before requests
// are accepted.
// Optional feature macro: LLC_PLRU_STATS_EN adds saturating 32-bit op counters.
// Without it, the stat ports are present and tied to zero.
module llc_plru_array #(
  parameter int NUM_SETS      = 16384,
  parameter int ASSOCIATIVITY = 16,
  localparam int INDEX_W      = $clog2(NUM_SETS),
  localparam int WAY_W        = $clog2(ASSOCIATIVITY),
  localparam int TREE_W       = ASSOCIATIVITY - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [INDEX_W-1:0]       req_set,
  input  logic [WAY_W-1:0]         req_way,
  input  logic [ASSOCIATIVITY-1:0] valid_mask,
  output logic                     rsp_valid,
  output logic [WAY_W-1:0]         rsp_way,
  output logic                     rsp_from_invalid,
  output logic                     init_done,
  output logic [31:0]              stat_touch_cnt,
  output logic [31:0]              stat_victim_cnt,
  output logic [31:0]              stat_fill_invalid_cnt
);

  typedef enum logic [1:0] {
    OP_TOUCH  = 2'b00,
    OP_VICTIM = 2'b01,
    OP_QUERY  = 2'b10,
    OP_NOP    = 2'b11
  } op_e;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e              state;
  logic [INDEX_W-1:0]  sweep_cnt;
  logic [TREE_W-1:0]   plru_mem [NUM_SETS];

  logic                accept;
  logic [TREE_W-1:0]   cur_vec;
  logic [TREE_W-1:0]   new_vec;
  logic [WAY_W-1:0]    tree_way;
  logic [WAY_W-1:0]    inv_way;
  logic                any_invalid;
  logic [WAY_W-1:0]    victim_way;
  logic [WAY_W-1:0]    sel_way;
  logic                sel_inv;
  logic                upd_en;
  logic [WAY_W-1:0]    upd_way;

  // Walk from the root following each node's LRU side; the leaf reached is the victim.
  // The vector is padded by one bit so node indices fit exactly in WAY_W bits.
  function automatic logic [WAY_W-1:0] tree_victim(input logic [TREE_W-1:0] vec);
    logic [ASSOCIATIVITY-1:0] v;
    logic [WAY_W-1:0]         node;
    logic [WAY_W-1:0]         way;
    logic                     b;
    v    = {1'b0, vec};
    node = '0;
    way  = '0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      b    = v[node];
      way  = (way << 1) | WAY_W'(b);
      node = (node << 1) + WAY_W'(1) + WAY_W'(b);
    end
    return way;
  endfunction

  // Mark every node on the path to way w as pointing to the opposite subtree.
  function automatic logic [TREE_W-1:0] tree_touch(input logic [TREE_W-1:0] vec,
                                                   input logic [WAY_W-1:0]  w);
    logic [ASSOCIATIVITY-1:0] v;
    logic [WAY_W-1:0]         node;
    logic [WAY_W-1:0]         wsh;
    logic                     b;
    v    = {1'b0, vec};
    node = '0;
    wsh  = w;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      b       = wsh[WAY_W-1];
      wsh     = wsh << 1;
      v[node] = ~b;
      node    = (node << 1) + WAY_W'(1) + WAY_W'(b);
    end
    return v[TREE_W-1:0];
  endfunction

  assign accept = req_valid && req_ready;

  // Victim selection and next-state computation. The array is written at the
  // acceptance edge and read combinationally, so a back-to-back request to the
  // same set already observes the updated vector.
  always_comb begin
    logic [ASSOCIATIVITY-1:0] inv;
    cur_vec     = plru_mem[req_set];
    tree_way    = tree_victim(cur_vec);
    inv         = ~valid_mask;
    inv_way     = '0;
    any_invalid = 1'b0;
    for (int i = 0; i < ASSOCIATIVITY; i++) begin
      if (inv[0] && !any_invalid) begin
        inv_way     = WAY_W'(i);
        any_invalid = 1'b1;
      end
      inv = inv >> 1;
    end
    victim_way = any_invalid ? inv_way : tree_way;

    sel_way = '0;
    sel_inv = 1'b0;
    upd_en  = 1'b0;
    upd_way = victim_way;
    case (op_e'(req_op))
      OP_TOUCH: begin
        sel_way = req_way;
        upd_en  = accept;
        upd_way = req_way;
      end
      OP_VICTIM: begin
        sel_way = victim_way;
        sel_inv = any_invalid;
        upd_en  = accept;
      end
      OP_QUERY: begin
        sel_way = victim_way;
        sel_inv = any_invalid;
      end
      default: begin
        sel_way = '0;
        sel_inv = 1'b0;
      end
    endcase
    new_vec = tree_touch(cur_vec, upd_way);
  end

  // Init/ready control FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_INIT;
      sweep_cnt        <= '0;
      req_ready        <= 1'b0;
      init_done        <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_way          <= '0;
      rsp_from_invalid <= 1'b0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_way          <= sel_way;
        rsp_from_invalid <= sel_inv;
      end
      case (state)
        ST_INIT: begin
          if (sweep_cnt == INDEX_W'(NUM_SETS - 1)) begin
            state     <= ST_READY;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end else begin
            sweep_cnt <= sweep_cnt + INDEX_W'(1);
          end
        end
        default: begin
          req_ready <= 1'b1;
          init_done <= 1'b1;
        end
      endcase
    end
  end

  // State array writes: zero-fill during the sweep, tree updates once ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        plru_mem[sweep_cnt] <= '0;
      end else if (upd_en) begin
        plru_mem[req_set] <= new_vec;
      end
    end
  end

`ifdef LLC_PLRU_STATS_EN
  // Saturating counters of accepted TOUCH/VICTIM ops and victims taken from invalid ways.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_touch_cnt        <= '0;
      stat_victim_cnt       <= '0;
      stat_fill_invalid_cnt <= '0;
    end else if (accept) begin
      if (op_e'(req_op) == OP_TOUCH && stat_touch_cnt != 32'hFFFF_FFFF)
        stat_touch_cnt <= stat_touch_cnt + 32'd1;
      if (op_e'(req_op) == OP_VICTIM && stat_victim_cnt != 32'hFFFF_FFFF)
        stat_victim_cnt <= stat_victim_cnt + 32'd1;
      if (op_e'(req_op) == OP_VICTIM && any_invalid &&
          stat_fill_invalid_cnt != 32'hFFFF_FFFF)
        stat_fill_invalid_cnt <= stat_fill_invalid_cnt + 32'd1;
    end
  end
`else
  assign stat_touch_cnt        = '0;
  assign stat_victim_cnt       = '0;
  assign stat_fill_invalid_cnt = '0;
`endif

endmodule

// File: tb/tb_llc_plru_array.sv
// tb_llc_plru_array: directed bench for llc_plru_array with NUM_SETS=16 and
// ASSOCIATIVITY=16. Expected values are hand-derived tree-PLRU results.
module tb_llc_plru_array;

  localparam int NUM_SETS = 16;
  localparam int ASSOC    = 16;
  localparam logic [1:0] OP_TOUCH  = 2'b00;
  localparam logic [1:0] OP_VICTIM = 2'b01;
  localparam logic [1:0] OP_QUERY  = 2'b10;
  localparam logic [1:0] OP_NOP    = 2'b11;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [3:0]  req_set;
  logic [3:0]  req_way;
  logic [15:0] valid_mask;
  logic        rsp_valid;
  logic [3:0]  rsp_way;
  logic        rsp_from_invalid;
  logic        init_done;
  logic [31:0] stat_touch_cnt;
  logic [31:0] stat_victim_cnt;
  logic [31:0] stat_fill_invalid_cnt;

  int checks = 0;
  int errors = 0;

  llc_plru_array #(.NUM_SETS(NUM_SETS), .ASSOCIATIVITY(ASSOC)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_set(req_set),
    .req_way(req_way),
    .valid_mask(valid_mask),
    .rsp_valid(rsp_valid),
    .rsp_way(rsp_way),
    .rsp_from_invalid(rsp_from_invalid),
    .init_done(init_done),
    .stat_touch_cnt(stat_touch_cnt),
    .stat_victim_cnt(stat_victim_cnt),
    .stat_fill_invalid_cnt(stat_fill_invalid_cnt)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle, then drive the next request 1 ns after the edge.
  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [3:0] s,
                               input logic [3:0] w, input logic [15:0] m);
    @(posedge clk);
    #1;
    req_valid  = v;
    req_op     = op;
    req_set    = s;
    req_way    = w;
    valid_mask = m;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the response currently on the outputs.
  task automatic checkOutput(input string tag, input logic ev, input logic [3:0] ew,
                             input logic ei);
    checkVal({tag, "_valid"}, 32'(rsp_valid), 32'(ev));
    if (ev) begin
      checkVal({tag, "_way"}, 32'(rsp_way), 32'(ew));
      checkVal({tag, "_inv"}, 32'(rsp_from_invalid), 32'(ei));
    end
  endtask

  // Count sampled cycles with req_ready low, flagging any response seen meanwhile.
  task automatic waitInit(output int n, output logic saw_rsp);
    n = 0;
    saw_rsp = 1'b0;
    while (!req_ready && n < 100) begin
      n++;
      if (rsp_valid) saw_rsp = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int   n;
    logic saw;

    rst = 1'b1;
    req_valid = 1'b0;
    req_op = OP_NOP;
    req_set = '0;
    req_way = '0;
    valid_mask = 16'hFFFF;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_ready", 32'(req_ready), 32'd0);
    checkVal("rst_init_done", 32'(init_done), 32'd0);
    checkVal("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkVal("rst_rsp_way", 32'(rsp_way), 32'd0);
    checkVal("rst_rsp_inv", 32'(rsp_from_invalid), 32'd0);
    checkVal("rst_stat_touch", stat_touch_cnt, 32'd0);

    // Release reset with a request held during INIT; it must be ignored.
    rst = 1'b0;
    req_valid = 1'b1;
    req_op = OP_QUERY;
    waitInit(n, saw);
    req_valid = 1'b0;
    checkVal("init_cycles", 32'(n), 32'd16);
    checkVal("init_no_rsp", 32'(saw), 32'd0);
    checkVal("init_done", 32'(init_done), 32'd1);
    @(posedge clk);
    #1;
    checkVal("init_ignored_req", 32'(rsp_valid), 32'd0);

    // Four back-to-back victims on a fully valid set 5.
    applyStimulus(1, OP_VICTIM, 4'd5, 4'd0, 16'hFFFF);
    applyStimulus(1, OP_VICTIM, 4'd5, 4'd0, 16'hFFFF);
    checkOutput("vic0", 1, 4'd0, 0);
    applyStimulus(1, OP_VICTIM, 4'd5, 4'd0, 16'hFFFF);
    checkOutput("vic1", 1, 4'd8, 0);
    applyStimulus(1, OP_VICTIM, 4'd5, 4'd0, 16'hFFFF);
    checkOutput("vic2", 1, 4'd4, 0);
    applyStimulus(0, OP_NOP, 4'd0, 4'd0, 16'hFFFF);
    checkOutput("vic3", 1, 4'd12, 0);
    applyStimulus(0, OP_NOP, 4'd0, 4'd0, 16'hFFFF);
    checkOutput("vic_idle", 0, 4'd0, 0);

    // Invalid fill on set 3, then two queries that must not move the state.
    applyStimulus(1, OP_VICTIM, 4'd3, 4'd0, 16'hFFF7);
    applyStimulus(1, OP_QUERY, 4'd3, 4'd0, 16'hFFFF);
    checkOutput("fill_inv", 1, 4'd3, 1);
    applyStimulus(1, OP_QUERY, 4'd3, 4'd0, 16'hFFFF);
    checkOutput("query0", 1, 4'd8, 0);
    applyStimulus(0, OP_NOP, 4'd0, 4'd0, 16'hFFFF);
    checkOutput("query1", 1, 4'd8, 0);

    // Touch followed immediately by a victim on the same set.
    applyStimulus(1, OP_TOUCH, 4'd2, 4'd0, 16'hFFFF);
    applyStimulus(1, OP_VICTIM, 4'd2, 4'd0, 16'hFFFF);
    checkOutput("touch2", 1, 4'd0, 0);
    applyStimulus(1, OP_NOP, 4'd1, 4'd5, 16'h0000);
    checkOutput("fwd_victim", 1, 4'd8, 0);
    applyStimulus(1, OP_TOUCH, 4'd9, 4'd0, 16'hFFFF);
    checkOutput("nop", 1, 4'd0, 0);
    applyStimulus(0, OP_NOP, 4'd0, 4'd0, 16'hFFFF);
    checkOutput("touch9", 1, 4'd0, 0);

    // Reset mid-operation, then again at sweep count 7.
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkVal("rst2_stat_victim", stat_victim_cnt, 32'd0);
    checkVal("rst2_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checkVal("mid_init_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    waitInit(n, saw);
    checkVal("restart_cycles", 32'(n), 32'd16);
    checkVal("restart_init_done", 32'(init_done), 32'd1);
    applyStimulus(1, OP_QUERY, 4'd9, 4'd0, 16'hFFFF);
    applyStimulus(0, OP_NOP, 4'd0, 4'd0, 16'hFFFF);
    checkOutput("set9_cleared", 1, 4'd0, 0);

    // Statistics: three touches and two victims, one of them from an invalid way.
    applyStimulus(1, OP_TOUCH, 4'd1, 4'd1, 16'hFFFF);
    applyStimulus(1, OP_TOUCH, 4'd1, 4'd2, 16'hFFFF);
    checkOutput("st_t1", 1, 4'd1, 0);
    applyStimulus(1, OP_TOUCH, 4'd1, 4'd3, 16'hFFFF);
    checkOutput("st_t2", 1, 4'd2, 0);
    applyStimulus(1, OP_VICTIM, 4'd4, 4'd0, 16'hFFFF);
    checkOutput("st_t3", 1, 4'd3, 0);
    applyStimulus(1, OP_VICTIM, 4'd6, 4'd0, 16'hFFFB);
    checkOutput("st_v1", 1, 4'd0, 0);
    applyStimulus(0, OP_NOP, 4'd0, 4'd0, 16'hFFFF);
    checkOutput("st_v2", 1, 4'd2, 1);
`ifdef LLC_PLRU_STATS_EN
    checkVal("stat_touch", stat_touch_cnt, 32'd3);
    checkVal("stat_victim", stat_victim_cnt, 32'd2);
    checkVal("stat_fill_inv", stat_fill_invalid_cnt, 32'd1);
`else
    checkVal("stat_touch", stat_touch_cnt, 32'd0);
    checkVal("stat_victim", stat_victim_cnt, 32'd0);
    checkVal("stat_fill_inv", stat_fill_invalid_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
